data_mem_arbiter: RTL and testbench

//  Shares the single data-memory port between two requesters: port 0 (CPU load/store) and port 1
//  (debug/DMA loader). Picks one request, issues it to data memory as a one-cycle memread or

---
 rtl/data_mem_arbiter_pkg.sv | 38 +++
 rtl/data_mem_arbiter_rr_arbiter2.sv | 22 ++
 rtl/data_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package data_mem_arbiter_pkg;

    // Default cycles from the end of the issue cycle until read data is valid.
    localparam int unsigned DEF_MEM_LAT = 3;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Command latched from the winning requester at grant time.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sign_mask;
    } cmd_t;

    // Bundle one requester's command fields.
    function automatic cmd_t make_cmd(
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [3:0]  sign_mask
    );
        cmd_t c;
        c.we        = we;
        c.addr      = addr;
        c.wdata     = wdata;
        c.sign_mask = sign_mask;
        return c;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way request arbiter: round-robin or fixed priority (port 0 wins).
module rr_arbiter2
    import data_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       mode,
    output logic       gnt
);

    // Lone requester always wins; ties go to port 0 or to the port not served last.
    always_comb begin
        gnt = 1'b0;
        unique case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = mode ? 1'b0 : ~last_grant;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single data-memory port between the CPU (port 0) and the
// debug/DMA loader (port 1). One transaction in flight at a time.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT  = DEF_MEM_LAT,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_sign_mask,
    output logic [31:0] p0_rdata,
    output logic        p0_done,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_sign_mask,
    output logic [31:0] p1_rdata,
    output logic        p1_done,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    localparam int unsigned CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       p0_rdata_q, p0_rdata_d;
    logic [31:0]       p1_rdata_q, p1_rdata_d;
    logic              p0_done_q, p0_done_d;
    logic              p1_done_q, p1_done_d;
    logic              arb_gnt;

    rr_arbiter2 u_arb (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant_q),
        .mode       (ARB_MODE != 0),
        .gnt        (arb_gnt)
    );

    // Next-state logic: grant in IDLE, one-cycle issue, count down latency, report.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        p0_done_d    = 1'b0;
        p1_done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    gnt_d   = arb_gnt;
                    cmd_d   = arb_gnt ? make_cmd(p1_we, p1_addr, p1_wdata, p1_sign_mask)
                                      : make_cmd(p0_we, p0_addr, p0_wdata, p0_sign_mask);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (!cmd_q.we) begin
                        if (gnt_q) p1_rdata_d = mem_rdata;
                        else       p0_rdata_d = mem_rdata;
                    end
                    if (gnt_q) p1_done_d = 1'b1;
                    else       p0_done_d = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_grant_d = gnt_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            p0_done_q    <= 1'b0;
            p1_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            p0_done_q    <= p0_done_d;
            p1_done_q    <= p1_done_d;
        end
    end

    // Outputs come only from registers and the decoded state.
    always_comb begin
        mem_addr      = cmd_q.addr;
        mem_wdata     = cmd_q.wdata;
        mem_sign_mask = cmd_q.sign_mask;
        mem_memread   = (state_q == ST_ISSUE) && !cmd_q.we;
        mem_memwrite  = (state_q == ST_ISSUE) &&  cmd_q.we;
        busy          = (state_q != ST_IDLE);
        p0_rdata      = p0_rdata_q;
        p1_rdata      = p1_rdata_q;
        p0_done       = p0_done_q;
        p1_done       = p1_done_q;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: one round-robin and one fixed-priority instance.
module tb_data_mem_arbiter;

    localparam int unsigned MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic [3:0]  p0_sign_mask = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic [3:0]  p1_sign_mask = '0;

    logic [31:0] a_p0_rdata, a_p1_rdata, a_addr, a_wdata, a_rdata;
    logic        a_p0_done, a_p1_done, a_rd, a_wr, a_busy;
    logic [3:0]  a_mask;
    logic [31:0] b_p0_rdata, b_p1_rdata, b_addr, b_wdata, b_rdata;
    logic        b_p0_done, b_p1_done, b_rd, b_wr, b_busy;
    logic [3:0]  b_mask;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_arbiter #(.MEM_LAT(MEM_LAT), .ARB_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_sign_mask(p0_sign_mask), .p0_rdata(a_p0_rdata), .p0_done(a_p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_sign_mask(p1_sign_mask), .p1_rdata(a_p1_rdata), .p1_done(a_p1_done),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_sign_mask(a_mask),
        .mem_memread(a_rd), .mem_memwrite(a_wr), .mem_rdata(a_rdata), .busy(a_busy)
    );

    data_mem_arbiter #(.MEM_LAT(MEM_LAT), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_sign_mask(p0_sign_mask), .p0_rdata(b_p0_rdata), .p0_done(b_p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_sign_mask(p1_sign_mask), .p1_rdata(b_p1_rdata), .p1_done(b_p1_done),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_sign_mask(b_mask),
        .mem_memread(b_rd), .mem_memwrite(b_wr), .mem_rdata(b_rdata), .busy(b_busy)
    );

    // Read contents of the modelled data memory.
    function automatic logic [31:0] rdata_of(input logic [31:0] addr);
        if (addr == 32'h0000_1004) return 32'hDEAD_BEEF;
        return {addr[15:0], ~addr[15:0]};
    endfunction

    // Memory models: data valid only in the cycle MEM_LAT edges after the issue cycle ends.
    int          a_pend = 0, b_pend = 0;
    logic [31:0] a_paddr = '0, b_paddr = '0;
    always @(posedge clk) begin
        if (a_rd) begin a_pend <= MEM_LAT; a_paddr <= a_addr; end
        else if (a_pend != 0) a_pend <= a_pend - 1;
        if (b_rd) begin b_pend <= MEM_LAT; b_paddr <= b_addr; end
        else if (b_pend != 0) b_pend <= b_pend - 1;
    end
    assign a_rdata = (a_pend == 1) ? rdata_of(a_paddr) : 32'hBAD0_BAD0;
    assign b_rdata = (b_pend == 1) ? rdata_of(b_paddr) : 32'hBAD0_BAD0;

    // Bus monitors: count protocol violations and record pulse cycles.
    int   a_viol = 0, b_viol = 0, a_pulses = 0, b_pulses = 0;
    logic a_prev = 1'b0, b_prev = 1'b0;
    int   a_pulse_cyc[$];
    always @(negedge clk) begin
        if (a_rd && a_wr) a_viol++;
        if ((a_rd || a_wr) && (a_prev || !a_busy)) a_viol++;
        if (b_rd && b_wr) b_viol++;
        if ((b_rd || b_wr) && (b_prev || !b_busy)) b_viol++;
        if (a_rd || a_wr) begin a_pulses++; a_pulse_cyc.push_back(cyc); end
        if (b_rd || b_wr) b_pulses++;
        a_prev = a_rd || a_wr;
        b_prev = b_rd || b_wr;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        p0_req = 1'b0; p1_req = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    // Wait (bounded) for a done pulse on instance sel (0 = round-robin, 1 = fixed).
    task automatic wait_done(input logic sel, input int limit,
                             output int cycles, output logic got0, output logic got1);
        cycles = 0;
        got0 = 1'b0;
        got1 = 1'b0;
        while (cycles < limit && !got0 && !got1) begin
            @(negedge clk);
            cycles++;
            got0 = sel ? b_p0_done : a_p0_done;
            got1 = sel ? b_p1_done : a_p1_done;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_busy, a_rd, a_wr, a_p0_done, a_p1_done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl: got %b want 00000", {a_busy, a_rd, a_wr, a_p0_done, a_p1_done});
        end
        checks++;
        if ({a_addr, a_wdata, a_mask, a_p0_rdata, a_p1_rdata} !== '0) begin
            errors++; $display("FAIL reset_data: addr=%h wdata=%h mask=%h r0=%h r1=%h want all 0",
                               a_addr, a_wdata, a_mask, a_p0_rdata, a_p1_rdata);
        end
        checks++;
        if ({b_busy, b_rd, b_wr, b_p0_done, b_p1_done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl_fp: got %b want 00000", {b_busy, b_rd, b_wr, b_p0_done, b_p1_done});
        end
    endtask

    task automatic test_read_p0();
        int n; logic g0, g1; int start;
        start = a_pulses;
        p0_we = 1'b0; p0_addr = 32'h1004; p0_sign_mask = 4'hF; p0_req = 1'b1;
        tick(1);
        checks++;
        if (a_rd !== 1'b1 || a_wr !== 1'b0 || a_addr !== 32'h1004) begin
            errors++; $display("FAIL t1_issue: rd=%b wr=%b addr=%h want 1 0 00001004", a_rd, a_wr, a_addr);
        end
        wait_done(1'b0, 10, n, g0, g1);
        p0_req = 1'b0;
        checks++;
        if (!(g0 && !g1) || n + 1 != 5) begin
            errors++; $display("FAIL t1_done: p0=%b p1=%b cycles=%0d want 1 0 5", g0, g1, n + 1);
        end
        checks++;
        if (a_p0_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL t1_rdata: got %h want deadbeef", a_p0_rdata);
        end
        tick(1);
        checks++;
        if (a_p0_done !== 1'b0) begin
            errors++; $display("FAIL t1_done_width: got %b want 0", a_p0_done);
        end
        tick(3);
        checks++;
        if (a_pulses - start != 1 || a_busy !== 1'b0) begin
            errors++; $display("FAIL t1_pulses: pulses=%0d busy=%b want 1 0", a_pulses - start, a_busy);
        end
    endtask

    task automatic test_write_p1();
        int n; logic g0, g1; logic [31:0] prev;
        p1_we = 1'b0; p1_addr = 32'h1010; p1_req = 1'b1;
        wait_done(1'b0, 10, n, g0, g1);
        p1_req = 1'b0;
        checks++;
        if (!g1 || g0 || a_p1_rdata !== rdata_of(32'h1010)) begin
            errors++; $display("FAIL t2_read: p1=%b p0=%b rdata=%h want 1 0 %h", g1, g0, a_p1_rdata, rdata_of(32'h1010));
        end
        prev = a_p1_rdata;
        tick(2);
        p1_we = 1'b1; p1_addr = 32'h1008; p1_wdata = 32'h1234_5678; p1_sign_mask = 4'b0100; p1_req = 1'b1;
        tick(1);
        checks++;
        if (a_wr !== 1'b1 || a_rd !== 1'b0 || a_addr !== 32'h1008 || a_wdata !== 32'h1234_5678 || a_mask !== 4'b0100) begin
            errors++; $display("FAIL t2_issue: wr=%b rd=%b addr=%h wdata=%h mask=%b want 1 0 00001008 12345678 0100",
                               a_wr, a_rd, a_addr, a_wdata, a_mask);
        end
        wait_done(1'b0, 10, n, g0, g1);
        p1_req = 1'b0;
        checks++;
        if (!g1 || g0 || n + 1 != 5 || a_p1_rdata !== prev) begin
            errors++; $display("FAIL t2_done: p1=%b p0=%b cycles=%0d rdata=%h want 1 0 5 %h", g1, g0, n + 1, a_p1_rdata, prev);
        end
        tick(1);
        checks++;
        if (a_p1_done !== 1'b0) begin
            errors++; $display("FAIL t2_done_width: got %b want 0", a_p1_done);
        end
        tick(2);
    endtask

    task automatic test_round_robin();
        int n; logic g0, g1; int start;
        logic [3:0] order;
        do_reset();
        start = a_pulse_cyc.size();
        p0_we = 1'b0; p0_addr = 32'h0100;
        p1_we = 1'b0; p1_addr = 32'h0200;
        p0_req = 1'b1; p1_req = 1'b1;
        order = '0;
        for (int i = 0; i < 4; i++) begin
            wait_done(1'b0, 12, n, g0, g1);
            order[i] = g1;
            checks++;
            if (!(g0 ^ g1) || (g0 && a_p0_rdata !== rdata_of(32'h0100)) || (g1 && a_p1_rdata !== rdata_of(32'h0200))) begin
                errors++; $display("FAIL t3_txn%0d: p0=%b p1=%b r0=%h r1=%h", i, g0, g1, a_p0_rdata, a_p1_rdata);
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        checks++;
        if (order !== 4'b1010) begin
            errors++; $display("FAIL t3_order: got %b want 1010 (bit i = port of txn i)", order);
        end
        checks++;
        if (a_pulse_cyc.size() - start < 4 ||
            a_pulse_cyc[start+1] - a_pulse_cyc[start] != 6 ||
            a_pulse_cyc[start+2] - a_pulse_cyc[start+1] != 6 ||
            a_pulse_cyc[start+3] - a_pulse_cyc[start+2] != 6) begin
            errors++; $display("FAIL t3_spacing: pulses=%0d want 4 pulses 6 cycles apart", a_pulse_cyc.size() - start);
        end
        tick(4);
    endtask

    task automatic test_fixed_priority();
        int n; logic g0, g1;
        do_reset();
        p0_we = 1'b0; p0_addr = 32'h0300;
        p1_we = 1'b0; p1_addr = 32'h0400;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_done(1'b1, 12, n, g0, g1);
            checks++;
            if (!g0 || g1 || b_p0_rdata !== rdata_of(32'h0300)) begin
                errors++; $display("FAIL t4_p0_%0d: p0=%b p1=%b r0=%h want 1 0 %h", i, g0, g1, b_p0_rdata, rdata_of(32'h0300));
            end
        end
        p0_req = 1'b0;
        wait_done(1'b1, 12, n, g0, g1);
        p1_req = 1'b0;
        checks++;
        if (!g1 || g0 || b_p1_rdata !== rdata_of(32'h0400)) begin
            errors++; $display("FAIL t4_p1: p1=%b p0=%b r1=%h want 1 0 %h", g1, g0, b_p1_rdata, rdata_of(32'h0400));
        end
        tick(4);
    endtask

    task automatic test_hold_and_abort();
        int n; logic g0, g1; int dones;
        do_reset();
        p0_we = 1'b0; p0_addr = 32'h2000; p0_req = 1'b1;
        tick(2);
        p0_addr = 32'h3000;
        tick(1);
        checks++;
        if (a_addr !== 32'h2000) begin
            errors++; $display("FAIL t5_addr_hold: got %h want 00002000", a_addr);
        end
        wait_done(1'b0, 10, n, g0, g1);
        p0_req = 1'b0;
        checks++;
        if (!g0 || a_p0_rdata !== rdata_of(32'h2000)) begin
            errors++; $display("FAIL t5_rdata: done=%b rdata=%h want 1 %h", g0, a_p0_rdata, rdata_of(32'h2000));
        end
        tick(2);
        p0_addr = 32'h1004; p0_req = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; p0_req = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (a_p0_done || a_p1_done) dones++;
        end
        checks++;
        if (dones != 0 || a_busy !== 1'b0) begin
            errors++; $display("FAIL t5_abort: dones=%0d busy=%b want 0 0", dones, a_busy);
        end
        p0_req = 1'b1;
        wait_done(1'b0, 10, n, g0, g1);
        p0_req = 1'b0;
        checks++;
        if (!g0 || n != 5 || a_p0_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL t5_after: done=%b cycles=%0d rdata=%h want 1 5 deadbeef", g0, n, a_p0_rdata);
        end
        tick(3);
    endtask

    task automatic test_bus_checks();
        checks++;
        if (a_viol != 0 || a_pulses == 0) begin
            errors++; $display("FAIL t6_bus_rr: violations=%0d pulses=%0d want 0 and >0", a_viol, a_pulses);
        end
        checks++;
        if (b_viol != 0 || b_pulses == 0) begin
            errors++; $display("FAIL t6_bus_fp: violations=%0d pulses=%0d want 0 and >0", b_viol, b_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_read_p0();
        test_write_p1();
        test_round_robin();
        test_fixed_priority();
        test_hold_and_abort();
        test_bus_checks();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
